// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit lab CPU: widths, ALU opcodes, mux selects.
// Used by both the execution unit and the control unit.
package cpu_pkg;

   localparam int unsigned CPU_DW   = 16;
   localparam int unsigned CPU_AW   = 16;
   localparam int unsigned CPU_NREG = 8;
   localparam int unsigned CPU_RAW  = 3;
   localparam int unsigned ALU_OPW  = 4;

   localparam logic [ALU_OPW-1:0] ALU_PASS_B = 4'b0000;
   localparam logic [ALU_OPW-1:0] ALU_PASS_A = 4'b0001;
   localparam logic [ALU_OPW-1:0] ALU_INC    = 4'b0010;
   localparam logic [ALU_OPW-1:0] ALU_DEC    = 4'b0011;
   localparam logic [ALU_OPW-1:0] ALU_ADD    = 4'b0100;
   localparam logic [ALU_OPW-1:0] ALU_SUB    = 4'b0101;
   localparam logic [ALU_OPW-1:0] ALU_SHR    = 4'b0110;
   localparam logic [ALU_OPW-1:0] ALU_SHL    = 4'b0111;
   localparam logic [ALU_OPW-1:0] ALU_AND    = 4'b1000;
   localparam logic [ALU_OPW-1:0] ALU_OR     = 4'b1001;
   localparam logic [ALU_OPW-1:0] ALU_XOR    = 4'b1010;
   localparam logic [ALU_OPW-1:0] ALU_NOT    = 4'b1011;

   localparam logic ADR_PC    = 1'b0;
   localparam logic ADR_REG   = 1'b1;
   localparam logic WB_ALU    = 1'b0;
   localparam logic WB_MEM    = 1'b1;
   localparam logic PCSRC_REL = 1'b0;
   localparam logic PCSRC_REG = 1'b1;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
   } alu_flags_t;

   // Sign-extend an 8-bit branch offset to the datapath width.
   function automatic logic [CPU_DW-1:0] sext8(input logic [7:0] x);
      return {{(CPU_DW-8){x[7]}}, x};
   endfunction

endpackage

// File: rtl/regfile8x16.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Same-cycle read of the write address returns the old contents.
module regfile8x16 #(
   parameter int unsigned DW   = 16,
   parameter int unsigned NREG = 8,
   parameter int unsigned RAW  = 3
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           we,
   input  logic [RAW-1:0] w_adr,
   input  logic [RAW-1:0] r_adr,
   input  logic [RAW-1:0] s_adr,
   input  logic [DW-1:0]  w_data,
   output logic [DW-1:0]  r_data,
   output logic [DW-1:0]  s_data
);

   logic [DW-1:0] regs [NREG];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
      end else if (we) begin
         regs[w_adr] <= w_data;
      end
   end

   assign r_data = regs[r_adr];
   assign s_data = regs[s_adr];

endmodule

// File: rtl/cpu_exec_unit.sv
// Execution unit: PC, IR, register file, ALU, write-back and address muxes.
// One control word per clock; flags are combinational and not stored here.
module cpu_exec_unit
   import cpu_pkg::*;
#(
   parameter int unsigned DW   = CPU_DW,
   parameter int unsigned AW   = CPU_AW,
   parameter int unsigned NREG = CPU_NREG
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    W_Adr,
   input  logic [2:0]    R_Adr,
   input  logic [2:0]    S_Adr,
   input  logic          adr_sel,
   input  logic          s_sel,
   input  logic          pc_ld,
   input  logic          pc_inc,
   input  logic          pc_sel,
   input  logic          ir_ld,
   input  logic          rw_en,
   input  logic [3:0]    alu_op,
   input  logic [DW-1:0] mem_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [DW-1:0] IR,
   output logic [DW-1:0] pc,
   output logic          N,
   output logic          Z,
   output logic          C
);

   logic [DW-1:0] a_op;
   logic [DW-1:0] b_op;
   logic [DW-1:0] alu_res;
   logic [DW:0]   sum;
   logic [DW-1:0] wb_data;
   alu_flags_t    flags;

   regfile8x16 #(
      .DW   (DW),
      .NREG (NREG),
      .RAW  (CPU_RAW)
   ) u_regfile (
      .clk    (clk),
      .reset  (reset),
      .we     (rw_en),
      .w_adr  (W_Adr),
      .r_adr  (R_Adr),
      .s_adr  (S_Adr),
      .w_data (wb_data),
      .r_data (a_op),
      .s_data (b_op)
   );

   // ALU: arithmetic done one bit wider so bit DW is the carry/borrow.
   always_comb begin
      sum     = '0;
      alu_res = '0;
      flags.c = 1'b0;
      case (alu_op)
         ALU_PASS_B: alu_res = b_op;
         ALU_PASS_A: alu_res = a_op;
         ALU_INC: begin
            sum     = {1'b0, b_op} + (DW+1)'(1);
            alu_res = sum[DW-1:0];
            flags.c = sum[DW];
         end
         ALU_DEC: begin
            sum     = {1'b0, b_op} - (DW+1)'(1);
            alu_res = sum[DW-1:0];
            flags.c = sum[DW];
         end
         ALU_ADD: begin
            sum     = {1'b0, a_op} + {1'b0, b_op};
            alu_res = sum[DW-1:0];
            flags.c = sum[DW];
         end
         ALU_SUB: begin
            sum     = {1'b0, a_op} - {1'b0, b_op};
            alu_res = sum[DW-1:0];
            flags.c = sum[DW];
         end
         ALU_SHR: begin
            alu_res = {1'b0, b_op[DW-1:1]};
            flags.c = b_op[0];
         end
         ALU_SHL: begin
            alu_res = {b_op[DW-2:0], 1'b0};
            flags.c = b_op[DW-1];
         end
         ALU_AND: alu_res = a_op & b_op;
         ALU_OR:  alu_res = a_op | b_op;
         ALU_XOR: alu_res = a_op ^ b_op;
         ALU_NOT: alu_res = ~b_op;
         default: alu_res = '0;
      endcase
      flags.n = alu_res[DW-1];
      flags.z = (alu_res == '0);
   end

   assign N = flags.n;
   assign Z = flags.z;
   assign C = flags.c;

   assign wb_data   = (s_sel == WB_MEM) ? mem_rdata : alu_res;
   assign mem_addr  = AW'((adr_sel == ADR_REG) ? a_op : pc);
   assign mem_wdata = b_op;

   // PC: load beats increment; relative target uses the IR held this cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= '0;
         IR <= '0;
      end else begin
         if (pc_ld) begin
            pc <= (pc_sel == PCSRC_REG) ? a_op : pc + DW'(sext8(IR[7:0]));
         end else if (pc_inc) begin
            pc <= pc + DW'(1);
         end
         if (ir_ld) IR <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Bench for cpu_exec_unit: directed scenarios plus random control words,
// each checked against an arithmetic reference model of the datapath.
module tb_cpu_exec_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  W_Adr, R_Adr, S_Adr;
   logic        adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld, rw_en;
   logic [3:0]  alu_op;
   logic [15:0] mem_rdata;
   logic [15:0] mem_addr, mem_wdata, IR, pc;
   logic        N, Z, C;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] m_r [8];
   logic [15:0] m_pc, m_ir;

   always #5 clk = ~clk;

   cpu_exec_unit dut (
      .clk(clk), .reset(reset), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
      .adr_sel(adr_sel), .s_sel(s_sel), .pc_ld(pc_ld), .pc_inc(pc_inc),
      .pc_sel(pc_sel), .ir_ld(ir_ld), .rw_en(rw_en), .alu_op(alu_op),
      .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .IR(IR), .pc(pc), .N(N), .Z(Z), .C(C)
   );

   // Reference ALU from the opcode table, using plain integer arithmetic.
   function automatic void ref_alu(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, output logic [15:0] res,
                                   output logic n, output logic z, output logic c);
      int ia, ib, r;
      ia = int'(a); ib = int'(b); r = 0; c = 1'b0;
      case (op)
         4'd0:  r = ib;
         4'd1:  r = ia;
         4'd2:  begin r = ib + 1;  c = (r > 65535); end
         4'd3:  begin r = ib - 1;  c = (ib == 0);   end
         4'd4:  begin r = ia + ib; c = (r > 65535); end
         4'd5:  begin r = ia - ib; c = (ia < ib);   end
         4'd6:  begin r = ib / 2;  c = ((ib % 2) != 0); end
         4'd7:  begin r = ib * 2;  c = (ib >= 32768);  end
         4'd8:  r = ia & ib;
         4'd9:  r = ia | ib;
         4'd10: r = ia ^ ib;
         4'd11: r = 65535 - ib;
         default: r = 0;
      endcase
      res = 16'(r & 'hFFFF);
      n   = res[15];
      z   = (res == 16'h0000);
   endfunction

   task automatic clear_ctl();
      W_Adr = 3'd0; R_Adr = 3'd0; S_Adr = 3'd0;
      adr_sel = 1'b0; s_sel = 1'b0; pc_ld = 1'b0; pc_inc = 1'b0;
      pc_sel = 1'b0; ir_ld = 1'b0; rw_en = 1'b0; alu_op = 4'd0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
      m_pc = 16'h0000;
      m_ir = 16'h0000;
   endtask

   // Apply the current control word for one clock, advancing the model too.
   task automatic tick();
      logic [15:0] a, b, res, npc, wv, rd;
      logic        n, z, c, we, il;
      logic [2:0]  wa;
      int          off;
      a = m_r[R_Adr]; b = m_r[S_Adr];
      ref_alu(alu_op, a, b, res, n, z, c);
      we = rw_en; wa = W_Adr; rd = mem_rdata; il = ir_ld;
      wv = s_sel ? rd : res;
      npc = m_pc;
      if (pc_ld) begin
         if (pc_sel) npc = a;
         else begin
            off = int'(m_ir[7:0]);
            if (off > 127) off = off - 256;
            npc = 16'((int'(m_pc) + off) & 'hFFFF);
         end
      end else if (pc_inc) begin
         npc = 16'((int'(m_pc) + 1) & 'hFFFF);
      end
      @(posedge clk); #1;
      if (we) m_r[wa] = wv;
      if (il) m_ir = rd;
      m_pc = npc;
   endtask

   task automatic write_reg(input logic [2:0] adr, input logic [15:0] val);
      clear_ctl();
      rw_en = 1'b1; s_sel = 1'b1; W_Adr = adr; mem_rdata = val;
      tick();
      clear_ctl();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_ctl();
      mem_rdata = 16'hA5A5;
      model_reset();
      #3;
      n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", pc); end
      n_checks++; if (IR !== 16'h0000) begin n_fail++; $display("FAIL reset_ir: got %h want 0000", IR); end
      n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
      n_checks++; if (mem_wdata !== 16'h0000) begin n_fail++; $display("FAIL reset_wdata: got %h want 0000", mem_wdata); end
      n_checks++; if ({N, Z, C} !== 3'b010) begin n_fail++; $display("FAIL reset_flags_pass: got %b want 010", {N, Z, C}); end
      alu_op = 4'b0011; #1;
      n_checks++; if ({N, Z, C} !== 3'b101) begin n_fail++; $display("FAIL reset_flags_dec: got %b want 101", {N, Z, C}); end
      alu_op = 4'b0101; #1;
      n_checks++; if ({N, Z, C} !== 3'b010) begin n_fail++; $display("FAIL reset_flags_sub: got %b want 010", {N, Z, C}); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      clear_ctl();
      reset = 1'b0;
   endtask

   task automatic test_fetch();
      clear_ctl();
      mem_rdata = 16'hE0CA; ir_ld = 1'b1; pc_inc = 1'b1;
      #1;
      n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL fetch_addr: got %h want 0000", mem_addr); end
      tick();
      n_checks++; if (IR !== 16'hE0CA) begin n_fail++; $display("FAIL fetch_ir: got %h want e0ca", IR); end
      n_checks++; if (pc !== 16'h0001) begin n_fail++; $display("FAIL fetch_pc: got %h want 0001", pc); end
   endtask

   task automatic test_add();
      write_reg(3'd1, 16'h7FFF);
      write_reg(3'd2, 16'h0001);
      R_Adr = 3'd1; S_Adr = 3'd3; alu_op = 4'b0100; W_Adr = 3'd3; rw_en = 1'b1;
      #1;
      n_checks++; if (mem_wdata !== m_r[3]) begin n_fail++; $display("FAIL rdw_old: got %h want %h", mem_wdata, m_r[3]); end
      S_Adr = 3'd2; #1;
      n_checks++; if ({N, Z, C} !== 3'b100) begin n_fail++; $display("FAIL add_ovf_flags: got %b want 100", {N, Z, C}); end
      tick();
      clear_ctl(); S_Adr = 3'd3; #1;
      n_checks++; if (mem_wdata !== 16'h8000) begin n_fail++; $display("FAIL add_ovf_res: got %h want 8000", mem_wdata); end
      write_reg(3'd1, 16'hFFFF);
      R_Adr = 3'd1; S_Adr = 3'd2; alu_op = 4'b0100; W_Adr = 3'd3; rw_en = 1'b1;
      #1;
      n_checks++; if ({N, Z, C} !== 3'b011) begin n_fail++; $display("FAIL add_wrap_flags: got %b want 011", {N, Z, C}); end
      tick();
      clear_ctl(); S_Adr = 3'd3; #1;
      n_checks++; if (mem_wdata !== 16'h0000) begin n_fail++; $display("FAIL add_wrap_res: got %h want 0000", mem_wdata); end
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a, b, res;
      logic [2:0]  nzc;
   } vec_t;

   task automatic test_flags();
      vec_t v [8];
      v[0] = '{4'b0101, 16'h0003, 16'h0005, 16'hFFFE, 3'b101};
      v[1] = '{4'b0011, 16'h1234, 16'h0000, 16'hFFFF, 3'b101};
      v[2] = '{4'b0111, 16'h0000, 16'h8001, 16'h0002, 3'b001};
      v[3] = '{4'b0110, 16'h0000, 16'h8001, 16'h4000, 3'b001};
      v[4] = '{4'b0010, 16'h0000, 16'hFFFF, 16'h0000, 3'b011};
      v[5] = '{4'b1011, 16'h0000, 16'h00FF, 16'hFF00, 3'b100};
      v[6] = '{4'b1000, 16'hF0F0, 16'hFF00, 16'hF000, 3'b100};
      v[7] = '{4'b1101, 16'hFFFF, 16'hFFFF, 16'h0000, 3'b010};
      for (int i = 0; i < 8; i++) begin
         write_reg(3'd1, v[i].a);
         write_reg(3'd2, v[i].b);
         R_Adr = 3'd1; S_Adr = 3'd2; alu_op = v[i].op; W_Adr = 3'd7; rw_en = 1'b1;
         #1;
         n_checks++;
         if ({N, Z, C} !== v[i].nzc) begin
            n_fail++; $display("FAIL flags_op%b: got %b want %b", v[i].op, {N, Z, C}, v[i].nzc);
         end
         tick();
         clear_ctl(); S_Adr = 3'd7; #1;
         n_checks++;
         if (mem_wdata !== v[i].res) begin
            n_fail++; $display("FAIL result_op%b: got %h want %h", v[i].op, mem_wdata, v[i].res);
         end
      end
   endtask

   task automatic test_mem_paths();
      write_reg(3'd4, 16'h0040);
      adr_sel = 1'b1; R_Adr = 3'd4; #1;
      n_checks++; if (mem_addr !== 16'h0040) begin n_fail++; $display("FAIL addr_reg: got %h want 0040", mem_addr); end
      adr_sel = 1'b0; #1;
      n_checks++; if (mem_addr !== m_pc) begin n_fail++; $display("FAIL addr_pc: got %h want %h", mem_addr, m_pc); end
      s_sel = 1'b1; rw_en = 1'b1; W_Adr = 3'd5; mem_rdata = 16'h1234; alu_op = 4'b0001;
      tick();
      clear_ctl();
      for (int i = 0; i < 8; i++) begin
         S_Adr = 3'(i); #1;
         n_checks++;
         if (mem_wdata !== m_r[i]) begin
            n_fail++; $display("FAIL wdata_r%0d: got %h want %h", i, mem_wdata, m_r[i]);
         end
      end
      S_Adr = 3'd5; #1;
      n_checks++; if (mem_wdata !== 16'h1234) begin n_fail++; $display("FAIL load_r5: got %h want 1234", mem_wdata); end
   endtask

   task automatic test_branches();
      write_reg(3'd6, 16'h0010);
      pc_ld = 1'b1; pc_sel = 1'b1; R_Adr = 3'd6; tick(); clear_ctl();
      n_checks++; if (pc !== 16'h0010) begin n_fail++; $display("FAIL jmp_reg10: got %h want 0010", pc); end
      ir_ld = 1'b1; mem_rdata = 16'h00FE; tick(); clear_ctl();
      pc_ld = 1'b1; pc_sel = 1'b0; ir_ld = 1'b1; mem_rdata = 16'h0002; tick(); clear_ctl();
      n_checks++; if (pc !== 16'h000E) begin n_fail++; $display("FAIL jmp_rel_back: got %h want 000e", pc); end
      n_checks++; if (IR !== 16'h0002) begin n_fail++; $display("FAIL jmp_ir_load: got %h want 0002", IR); end
      pc_ld = 1'b1; pc_sel = 1'b0; tick(); clear_ctl();
      n_checks++; if (pc !== 16'h0010) begin n_fail++; $display("FAIL jmp_rel_fwd: got %h want 0010", pc); end
      write_reg(3'd6, 16'h0100);
      pc_ld = 1'b1; pc_inc = 1'b1; pc_sel = 1'b1; R_Adr = 3'd6; tick(); clear_ctl();
      n_checks++; if (pc !== 16'h0100) begin n_fail++; $display("FAIL ld_over_inc: got %h want 0100", pc); end
      write_reg(3'd6, 16'hFFFF);
      pc_ld = 1'b1; pc_sel = 1'b1; R_Adr = 3'd6; tick(); clear_ctl();
      pc_inc = 1'b1; tick(); clear_ctl();
      n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL pc_wrap: got %h want 0000", pc); end
      rw_en = 1'b1; s_sel = 1'b1; pc_inc = 1'b1; W_Adr = 3'd2; mem_rdata = 16'hBEEF;
      tick(); clear_ctl(); S_Adr = 3'd2; #1;
      n_checks++; if ({pc, mem_wdata} !== {16'h0001, 16'hBEEF}) begin
         n_fail++; $display("FAIL ldi: got pc=%h r2=%h want pc=0001 r2=beef", pc, mem_wdata);
      end
   endtask

   task automatic test_random();
      logic [15:0] res, ea;
      logic        n, z, c;
      for (int k = 0; k < 300; k++) begin
         W_Adr = 3'($urandom); R_Adr = 3'($urandom); S_Adr = 3'($urandom);
         adr_sel = 1'($urandom); s_sel = 1'($urandom); pc_sel = 1'($urandom);
         pc_ld = ($urandom_range(0, 3) == 0); pc_inc = 1'($urandom);
         ir_ld = 1'($urandom); rw_en = 1'($urandom);
         alu_op = 4'($urandom); mem_rdata = 16'($urandom);
         #1;
         ref_alu(alu_op, m_r[R_Adr], m_r[S_Adr], res, n, z, c);
         ea = adr_sel ? m_r[R_Adr] : m_pc;
         n_checks++;
         if ({mem_addr, mem_wdata, N, Z, C} !== {ea, m_r[S_Adr], n, z, c}) begin
            n_fail++;
            $display("FAIL rnd_comb[%0d]: got addr=%h wd=%h nzc=%b want addr=%h wd=%h nzc=%b",
                     k, mem_addr, mem_wdata, {N, Z, C}, ea, m_r[S_Adr], {n, z, c});
         end
         tick();
         n_checks++;
         if ({pc, IR} !== {m_pc, m_ir}) begin
            n_fail++; $display("FAIL rnd_state[%0d]: got pc=%h ir=%h want pc=%h ir=%h", k, pc, IR, m_pc, m_ir);
         end
      end
      clear_ctl();
   endtask

   task automatic test_reset_mid_write();
      write_reg(3'd3, 16'h5A5A);
      rw_en = 1'b1; s_sel = 1'b1; W_Adr = 3'd5; mem_rdata = 16'hABCD;
      pc_inc = 1'b1; ir_ld = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if ({pc, IR, mem_addr} !== 48'h0) begin
         n_fail++; $display("FAIL async_rst: got pc=%h ir=%h addr=%h want 0", pc, IR, mem_addr);
      end
      @(posedge clk); #1;
      S_Adr = 3'd5; #1;
      n_checks++; if (mem_wdata !== 16'h0000) begin n_fail++; $display("FAIL rst_discard: got %h want 0000", mem_wdata); end
      @(negedge clk);
      clear_ctl();
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 8; i++) begin
         S_Adr = 3'(i); #1;
         n_checks++;
         if (mem_wdata !== m_r[i]) begin
            n_fail++; $display("FAIL rst_r%0d: got %h want %h", i, mem_wdata, m_r[i]);
         end
      end
      clear_ctl();
      mem_rdata = 16'h1111; ir_ld = 1'b1; pc_inc = 1'b1;
      tick(); clear_ctl();
      n_checks++; if ({pc, IR} !== {16'h0001, 16'h1111}) begin
         n_fail++; $display("FAIL post_rst_fetch: got pc=%h ir=%h want 0001 1111", pc, IR);
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_add();
      test_flags();
      test_mem_paths();
      test_branches();
      test_random();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
